deserializer: RTL
=================

// Module: deserializer
// PURPOSE
//  Receive end of the serializer link: samples serial_in_i on enable_i, frames words on start_i, rebuilds
//  DATA_WIDTH-bit parallel words, MSB first. With HAS_ECC=1 it also takes CODE_BITS parity bits after the
//  data, recomputes them through hamming_encode and flags any mismatch. Output is a registered word with a
//  valid/ready handshake. The link cannot be stalled, so a word that finds the output still full is dropped
//  and reported.
// PARAMETERS
//  DATA_WIDTH  8  payload bits per frame (>=3 when HAS_ECC=1)
//  HAS_ECC     0  1: frame carries CODE_BITS Hamming parity bits after data (CODE_BITS from hamming_defines.svh)
// PORTS
//  clk_i           in   1           clock, all state on rising edge
//  rst_n_i         in   1           asynchronous active-low reset
//  serial_in_i     in   1           serial bit, valid when enable_i=1
//  enable_i        in   1           bit strobe
//  start_i         in   1           first bit of frame (data MSB); only honoured together with enable_i
//  parallel_out_o  out  DATA_WIDTH  received word, stable while valid_out_o=1
//  valid_out_o     out  1           word available
//  ready_i         in   1           consumer accepts word when valid_out_o&&ready_i
//  ecc_error_o     out  1           qualified by valid_out_o: recomputed parity != received parity (0 if HAS_ECC=0)
//  overrun_o       out  1           1-cycle pulse: completed frame dropped, output register occupied
// BEHAVIOUR
//  Reset (async assert, sync release): FSM=IDLE, counters 0, parallel_out_o=0, valid_out_o=0,
//   ecc_error_o=0, overrun_o=0.
//  FRAME_LEN = DATA_WIDTH + (HAS_ECC ? CODE_BITS : 0). A bit is accepted only on a cycle with enable_i=1.
//  FSM states:
//   IDLE: enable_i&&start_i -> shift bit in as data MSB, bit_cnt=1, go SHIFT_DATA.
//     enable_i without start_i is ignored.
//   SHIFT_DATA: enable_i -> shift bit into data reg (left shift, new bit at LSB), bit_cnt++.
//     On the DATA_WIDTH-th bit: HAS_ECC=0 -> frame done; HAS_ECC=1 -> go SHIFT_PARITY.
//   SHIFT_PARITY (ECC only): enable_i -> shift bit into parity reg, MSB first.
//     On the CODE_BITS-th bit -> frame done.
//     Cycle after entering SHIFT_PARITY: pulse hamming_encode valid_in_i with the data reg. The encoder
//     result is registered by its valid_out_o and is ready before the last parity bit (CODE_BITS>=2).
//   Gaps: enable_i=0 in any shift state holds all state; there is no timeout.
//   start_i&&enable_i in any shift state aborts the partial frame, with no output and no flag, and restarts
//     with this bit as the new MSB.
//  Frame done (bit N sampled in cycle N), next state IDLE. In cycle N+1:
//   output empty, or being drained this cycle (valid_out_o&&ready_i) -> parallel_out_o=data,
//     ecc_error_o=(parity_reg!=encoder parity), valid_out_o=1.
//   otherwise -> frame dropped, overrun_o=1 for that cycle, held output unchanged.
//  Latency: last frame bit to valid_out_o is exactly 1 cycle, for both HAS_ECC values.
//  Handshake: valid_out_o stays high, with data and ecc_error_o stable, until ready_i.
//   valid&&ready with no new word -> valid_out_o=0 next cycle.
//   Back-to-back frames from a gap-free serializer are sustained with ready_i held 1.
//  ECC is detect-only. Data is never corrected. Errors in the parity bits also set ecc_error_o.
//  Reset mid-frame: partial frame discarded, output register cleared, no overrun_o.
// TESTING (DATA_WIDTH=8 unless noted)
//  1 HAS_ECC=0, frame 0xA5 (bits 1,0,1,0,0,1,0,1), enable every cycle, ready_i=1 -> parallel_out_o=0xA5,
//    valid_out_o high 1 cycle, 1 cycle after bit 8.
//  2 Same frame with enable_i low for 3 cycles after bit 4 -> 0xA5, valid 1 cycle after bit 8, no early valid.
//  3 start_i at bit 5 of frame 0xFF, then full frame 0x3C -> only 0x3C delivered, overrun_o never asserted.
//  4 ready_i=0, frames 0x11 then 0x22 -> output holds 0x11, overrun_o pulses once after 0x22's last bit;
//    ready_i=1 -> 0x11 consumed, valid_out_o=0.
//  5 HAS_ECC=1, frame 0x5A plus correct parity -> ecc_error_o=0. Same frame with data bit 3 flipped ->
//    ecc_error_o=1, parallel_out_o=0x52.
//  6 rst_n_i low during bit 5 with valid_out_o=1 -> outputs 0 immediately. After release, frame 0xC3 is
//    received correctly.

Source files
------------

// File: rtl/deserializer.sv
// deserializer: serial-to-parallel frame receiver with optional Hamming parity check.
// Revision 1.0 - initial release.
`default_nettype none

module deserializer #(
    parameter int DATA_WIDTH = 8,
    parameter int HAS_ECC    = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  serial_in_i,
    input  logic                  enable_i,
    input  logic                  start_i,
    output logic [DATA_WIDTH-1:0] parallel_out_o,
    output logic                  valid_out_o,
    input  logic                  ready_i,
    output logic                  ecc_error_o,
    output logic                  overrun_o
);

    function automatic int f_code_bits(input int w);
        int r;
        r = 2;
        while ((1 << r) < (w + r + 1)) r = r + 1;
        return r;
    endfunction

    localparam int c_code_bits = f_code_bits(DATA_WIDTH);
    localparam int c_cnt_w     = $clog2(DATA_WIDTH + 1);
    localparam logic [DATA_WIDTH-1:0] c_one = DATA_WIDTH'(1);

    // Data bits occupy the non-power-of-two codeword positions, LSB first;
    // parity bit j covers every position whose index has bit j set.
    function automatic logic [DATA_WIDTH-1:0] f_mask(input int j);
        logic [DATA_WIDTH-1:0] m;
        int k;
        m = '0;
        k = 0;
        for (int pos = 1; pos <= DATA_WIDTH + c_code_bits; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if ((((pos >> j) & 1) != 0) && (k < DATA_WIDTH)) m = m | (c_one << k);
                k = k + 1;
            end
        end
        return m;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2
    } state_t;

    state_t                  r_state;
    logic [c_cnt_w-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [c_code_bits-2:0]  r_par;
    logic                    r_enc_go;
    logic [c_code_bits-1:0]  r_enc_par;
    logic [DATA_WIDTH-1:0]   r_dout;
    logic                    r_valid;
    logic                    r_ecc;
    logic                    r_overrun;

    logic                    w_start;
    logic [DATA_WIDTH-1:0]   w_data_next;
    logic [c_code_bits-1:0]  w_par_next;
    logic [c_code_bits-1:0]  w_enc_calc;
    logic                    w_data_last;
    logic                    w_par_last;
    logic                    w_frame_done;
    logic [DATA_WIDTH-1:0]   w_frame_word;
    logic                    w_frame_err;
    logic                    w_can_load;

    for (genvar j = 0; j < c_code_bits; j++) begin : g_enc
        assign w_enc_calc[j] = ^(r_data & f_mask(j));
    end

    // The last parity bit is never stored; it is taken straight off the line.
    assign w_start      = enable_i && start_i;
    assign w_data_next  = {r_data[DATA_WIDTH-2:0], serial_in_i};
    assign w_par_next   = {r_par, serial_in_i};
    assign w_data_last  = (r_state == S_DATA) && enable_i && !start_i
                          && (r_cnt == c_cnt_w'(DATA_WIDTH - 1));
    assign w_par_last   = (r_state == S_PARITY) && enable_i && !start_i
                          && (r_cnt == c_cnt_w'(c_code_bits - 1));
    assign w_frame_done = (HAS_ECC != 0) ? w_par_last : w_data_last;
    assign w_frame_word = (HAS_ECC != 0) ? r_data : w_data_next;
    assign w_frame_err  = (HAS_ECC != 0) ? (w_par_next != r_enc_par) : 1'b0;
    assign w_can_load   = !r_valid || ready_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_data    <= '0;
            r_par     <= '0;
            r_enc_go  <= 1'b0;
            r_enc_par <= '0;
            r_dout    <= '0;
            r_valid   <= 1'b0;
            r_ecc     <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            r_enc_go  <= 1'b0;
            if (r_enc_go) r_enc_par <= w_enc_calc;

            if (r_valid && ready_i) r_valid <= 1'b0;
            if (w_frame_done) begin
                if (w_can_load) begin
                    r_dout  <= w_frame_word;
                    r_ecc   <= w_frame_err;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_data  <= w_data_next;
                        r_cnt   <= c_cnt_w'(1);
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_start) begin
                        r_data <= w_data_next;
                        r_cnt  <= c_cnt_w'(1);
                    end else if (enable_i) begin
                        r_data <= w_data_next;
                        if (w_data_last) begin
                            r_cnt <= '0;
                            if (HAS_ECC != 0) begin
                                r_state  <= S_PARITY;
                                r_enc_go <= 1'b1;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_cnt <= r_cnt + c_cnt_w'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (w_start) begin
                        r_data  <= w_data_next;
                        r_cnt   <= c_cnt_w'(1);
                        r_state <= S_DATA;
                    end else if (enable_i) begin
                        r_par <= w_par_next[c_code_bits-2:0];
                        if (w_par_last) begin
                            r_cnt   <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + c_cnt_w'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign parallel_out_o = r_dout;
    assign valid_out_o    = r_valid;
    assign ecc_error_o    = r_ecc;
    assign overrun_o      = r_overrun;

endmodule

`default_nettype wire
